mio_counter_x: RTL and testbench



---
 rtl/mio_counter_pkg.sv | 28 ++
 rtl/mio_counter_ch.sv | 77 +++++++
 rtl/mio_counter_x.sv | 82 ++++++++
 tb/tb_mio_counter_x.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mio_counter_pkg.sv
// Shared encodings for the MIO three-channel down-counter: modes, bus selects
// and the control-register field layout.
package mio_counter_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    localparam logic [1:0] SEL_CH0  = 2'b00;
    localparam logic [1:0] SEL_CH1  = 2'b01;
    localparam logic [1:0] SEL_CH2  = 2'b10;
    localparam logic [1:0] SEL_CTRL = 2'b11;

    localparam int NUM_CH   = 3;
    // Each channel owns a 3-bit field: mode in the low two bits, enable above.
    localparam int FIELD_W  = 3;
    localparam int MODE_OFS = 0;
    localparam int EN_OFS   = 2;
    localparam int CTRL_W   = NUM_CH * FIELD_W;

    function automatic int field_lsb(input int ch);
        return ch * FIELD_W;
    endfunction

endpackage

// File: rtl/mio_counter_ch.sv
// One down-counter channel: holds reload/count/out and applies loads,
// control-write clears and tick-driven count steps.
module mio_counter_ch
    import mio_counter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        load,
    input  logic [31:0] load_val,
    input  mode_e       mode,
    input  logic        en,
    input  logic        ctrl_wr,
    output logic [31:0] count,
    output logic        out
);

    logic [31:0] reload_reg, reload_next;
    logic [31:0] count_reg, count_next;
    logic        out_reg, out_next;
    logic        step;

    assign step = tick && en && (mode != MODE_RSVD) && (count_reg != 32'd0);

    always_comb begin
        reload_next = reload_reg;
        count_next  = count_reg;
        out_next    = out_reg;
        // The periodic pulse lasts exactly one clock regardless of tick phase.
        if (mode == MODE_PERIODIC) begin
            out_next = 1'b0;
        end
        if (load) begin
            reload_next = load_val;
            count_next  = load_val;
            out_next    = 1'b0;
        end else if (ctrl_wr) begin
            out_next = 1'b0;
        end else if (step) begin
            if (count_reg > 32'd1) begin
                count_next = count_reg - 32'd1;
            end else begin
                case (mode)
                    MODE_ONESHOT: begin
                        count_next = 32'd0;
                        out_next   = 1'b1;
                    end
                    MODE_PERIODIC: begin
                        count_next = reload_reg;
                        out_next   = 1'b1;
                    end
                    MODE_SQUARE: begin
                        count_next = reload_reg;
                        out_next   = ~out_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_reg <= 32'd0;
            count_reg  <= 32'd0;
            out_reg    <= 1'b0;
        end else begin
            reload_reg <= reload_next;
            count_reg  <= count_next;
            out_reg    <= out_next;
        end
    end

    assign count = count_reg;
    assign out   = out_reg;

endmodule

// File: rtl/mio_counter_x.sv
// MIO three-channel programmable down-counter: shared prescaler, control
// register, write decode and read mux around three channel instances.
module mio_counter_x
    import mio_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        counter_we,
    input  logic [1:0]  counter_sel,
    input  logic [31:0] Peripheral_in,
    output logic [31:0] counter_out,
    output logic        counter0_out,
    output logic        counter1_out,
    output logic        counter2_out
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    logic [15:0]       presc_reg;
    logic              tick;
    logic [CTRL_W-1:0] ctrl_reg;
    logic              ctrl_wr;
    logic [31:0]       count_arr [NUM_CH];
    logic [NUM_CH-1:0] out_bits;

    assign tick    = (presc_reg == PRESC_MAX);
    assign ctrl_wr = counter_we && (counter_sel == SEL_CTRL);

    // Free-running; bus writes never realign it, so tick phase is arbitrary.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= 16'd0;
        end else if (tick) begin
            presc_reg <= 16'd0;
        end else begin
            presc_reg <= presc_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg <= '0;
        end else if (ctrl_wr) begin
            ctrl_reg <= Peripheral_in[CTRL_W-1:0];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            mio_counter_ch u_ch (
                .clk      (clk),
                .rst      (rst),
                .tick     (tick),
                .load     (counter_we && (counter_sel == 2'(gi))),
                .load_val (Peripheral_in),
                .mode     (mode_e'(ctrl_reg[field_lsb(gi) + MODE_OFS +: 2])),
                .en       (ctrl_reg[field_lsb(gi) + EN_OFS]),
                .ctrl_wr  (ctrl_wr),
                .count    (count_arr[gi]),
                .out      (out_bits[gi])
            );
        end
    endgenerate

    always_comb begin
        counter_out = 32'd0;
        case (counter_sel)
            SEL_CH0:  counter_out = count_arr[0];
            SEL_CH1:  counter_out = count_arr[1];
            SEL_CH2:  counter_out = count_arr[2];
            SEL_CTRL: counter_out = {{(32-CTRL_W){1'b0}}, ctrl_reg};
            default:  counter_out = 32'd0;
        endcase
    end

    assign counter0_out = out_bits[0];
    assign counter1_out = out_bits[1];
    assign counter2_out = out_bits[2];

endmodule

// File: tb/tb_mio_counter_x.sv
// Scoreboard bench for mio_counter_x: stimulus queues expected read/status
// values, a negedge monitor pops and compares them against the selected DUT.
module tb_mio_counter_x;

    logic        clk;
    logic        rst_a, rst_b;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [31:0] a_out, b_out;
    logic        a_c0, a_c1, a_c2, b_c0, b_c1, b_c2;

    mio_counter_x #(.PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst_a), .counter_we(we), .counter_sel(sel),
        .Peripheral_in(din), .counter_out(a_out),
        .counter0_out(a_c0), .counter1_out(a_c1), .counter2_out(a_c2)
    );

    mio_counter_x #(.PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst_b), .counter_we(we), .counter_sel(sel),
        .Peripheral_in(din), .counter_out(b_out),
        .counter0_out(b_c0), .counter1_out(b_c1), .counter2_out(b_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        string       tag;
        logic [31:0] val;
        logic [2:0]  outs;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic chk;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] got_v;
    logic [2:0]  got_o;

    // Monitor: state is sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: check requested with empty queue");
            end else begin
                e = sb.pop_front();
                got_v = (e.dut == 1) ? b_out : a_out;
                got_o = (e.dut == 1) ? {b_c2, b_c1, b_c0} : {a_c2, a_c1, a_c0};
                if (got_v !== e.val || got_o !== e.outs) begin
                    n_bad++;
                    $display("FAIL %s: got counter_out=%0d outs=%b, expected counter_out=%0d outs=%b",
                             e.tag, got_v, got_o, e.val, e.outs);
                end
            end
        end
    end

    // One bus cycle: inputs apply at the closing edge; a check sees the state
    // left by the previous edge.
    task automatic cyc(input logic w, input logic [1:0] s, input logic [31:0] d,
                       input bit c, input int dut, input string tag,
                       input logic [31:0] v, input logic [2:0] o);
        exp_t x;
        we  = w;
        sel = s;
        din = d;
        if (c) begin
            x.dut = dut; x.tag = tag; x.val = v; x.outs = o;
            sb.push_back(x);
            chk = 1'b1;
        end else begin
            chk = 1'b0;
        end
        @(posedge clk);
        #1;
        we  = 1'b0;
        chk = 1'b0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] d);
        cyc(1'b1, s, d, 1'b0, 0, "", 32'd0, 3'b000);
    endtask

    task automatic rd(input int dut, input logic [1:0] s, input string tag,
                      input logic [31:0] v, input logic [2:0] o);
        cyc(1'b0, s, 32'd0, 1'b1, dut, tag, v, o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_idx;
        rst_a = 1'b1; rst_b = 1'b1;
        we = 1'b0; sel = 2'b00; din = 32'd0; chk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd(0, 2'd0, "reset_held_sel0", 32'd0, 3'b000);
        rst_a = 1'b0;
        for (int s = 0; s < 4; s++)
            rd(0, 2'(s), $sformatf("reset_sel%0d", s), 32'd0, 3'b000);

        // ch1 periodic, load 4
        wr(2'd1, 32'd4);
        wr(2'd3, 32'h028);
        for (int i = 0; i < 10; i++)
            rd(0, 2'd1, $sformatf("periodic_ch1[%0d]", i), 32'(4 - (i % 4)),
               (i > 0 && (i % 4) == 0) ? 3'b010 : 3'b000);

        // ch0 one-shot, load 3 then 2; ch1 now frozen at 2
        wr(2'd3, 32'h004);
        wr(2'd0, 32'd3);
        rd(0, 2'd0, "oneshot_3", 32'd3, 3'b000);
        rd(0, 2'd0, "oneshot_2", 32'd2, 3'b000);
        rd(0, 2'd0, "oneshot_1", 32'd1, 3'b000);
        rd(0, 2'd0, "oneshot_fire", 32'd0, 3'b001);
        rd(0, 2'd0, "oneshot_sticky", 32'd0, 3'b001);
        rd(0, 2'd1, "ch1_disabled_frozen", 32'd2, 3'b001);
        rd(0, 2'd3, "ctrl_readback", 32'h004, 3'b001);
        wr(2'd0, 32'd2);
        rd(0, 2'd0, "oneshot_reload_2", 32'd2, 3'b000);
        rd(0, 2'd0, "oneshot_reload_1", 32'd1, 3'b000);
        rd(0, 2'd0, "oneshot_refire", 32'd0, 3'b001);

        // ch2 square, load 5: period 10
        wr(2'd2, 32'd5);
        wr(2'd3, 32'h180);
        for (int j = 0; j < 17; j++)
            rd(0, 2'd2, $sformatf("square_ch2[%0d]", j), 32'(5 - (j % 5)),
               {((j / 5) % 2 == 1), 2'b00});
        wr(2'd3, 32'h000);
        rd(0, 2'd2, "square_frozen_a", 32'd3, 3'b000);
        rd(0, 2'd2, "square_frozen_b", 32'd3, 3'b000);

        // Write landing on a terminal tick wins; load 0 never fires
        wr(2'd3, 32'h028);
        rd(0, 2'd1, "pre_collide", 32'd2, 3'b000);
        wr(2'd1, 32'd7);
        rd(0, 2'd1, "write_wins", 32'd7, 3'b000);
        rd(0, 2'd1, "after_write_dec", 32'd6, 3'b000);
        wr(2'd1, 32'd0);
        for (int k = 0; k < 4; k++)
            rd(0, 2'd1, $sformatf("load0_idle[%0d]", k), 32'd0, 3'b000);

        // PRESCALE=4 instance: periodic load 2 -> pulse every 8 cycles
        rst_b = 1'b0;
        wr(2'd1, 32'd2);
        wr(2'd3, 32'h028);
        for (int i = 0; i < 13; i++) begin
            e_idx = 2 + i;
            rd(1, 2'd1, $sformatf("presc4_ch1[e%0d]", e_idx),
               ((e_idx / 4) % 2 == 1) ? 32'd1 : 32'd2,
               (e_idx >= 8 && (e_idx % 8) == 0) ? 3'b010 : 3'b000);
        end
        rst_b = 1'b1;
        rd(1, 2'd1, "presc4_pre_reset", 32'd1, 3'b000);
        rd(1, 2'd1, "presc4_reset_ch1", 32'd0, 3'b000);
        rd(1, 2'd3, "presc4_reset_ctrl", 32'd0, 3'b000);

        @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
